// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues PC fetch requests to instruction memory under a
// credit limit, pairs in-order responses with their PC tags, and buffers them in
// a small FIFO for decode. A flush empties the buffers and drains late responses.
module instr_fetch_unit #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [DATA_W-1:0] i_pc,
  input  logic              i_pc_valid,
  output logic              o_pc_ready,
  input  logic              i_flush,
  output logic              o_imem_req_valid,
  output logic [DATA_W-1:0] o_imem_addr,
  input  logic              i_imem_req_ready,
  input  logic              i_imem_rsp_valid,
  input  logic [DATA_W-1:0] i_imem_rsp_data,
  output logic              o_inst_valid,
  output logic [DATA_W-1:0] o_inst,
  output logic [DATA_W-1:0] o_inst_pc,
  input  logic              i_inst_ready,
  output logic              o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            state;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     drop_count;
  logic [AW-1:0]     tag_wr, tag_rd;
  logic [AW-1:0]     fifo_wr, fifo_rd;

  logic [DATA_W-1:0] tag_mem   [DEPTH];
  logic [DATA_W-1:0] fifo_pc   [DEPTH];
  logic [DATA_W-1:0] fifo_inst [DEPTH];

  logic              running;
  logic              credit_ok;
  logic              accept;
  logic              rsp_any;
  logic              rsp_take;
  logic              pop;
  logic [CW-1:0]     drop_load;

  // Handshake and bookkeeping terms derived from the current state.
  assign running   = (state == RUN);
  // Reserve a buffer slot for every request in flight so responses never stall.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW + 1)'(DEPTH);
  // Reset gating keeps the request quiet while reset is held, since i_pc_valid is unregistered.
  assign o_imem_req_valid = i_reset_n & i_pc_valid & credit_ok & ~i_flush & running;
  assign o_imem_addr      = i_pc;
  assign o_pc_ready       = o_imem_req_valid & i_imem_req_ready;
  assign accept           = o_pc_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_any   = i_imem_rsp_valid & (outstanding != '0);
  assign rsp_take  = rsp_any & running & ~i_flush;
  assign drop_load = outstanding - CW'(rsp_any);

  assign o_inst_valid = (fifo_count != '0) & running;
  assign pop          = o_inst_valid & i_inst_ready & ~i_flush;
  assign o_inst       = o_inst_valid ? fifo_inst[fifo_rd] : '0;
  assign o_inst_pc    = o_inst_valid ? fifo_pc[fifo_rd]   : '0;
  assign o_busy       = (outstanding != '0) | (fifo_count != '0) | (state == DRAIN);

  // Control state: counts, pointers and the RUN/DRAIN sequencing.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= RUN;
      outstanding <= '0;
      fifo_count  <= '0;
      drop_count  <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
    end else if (state == RUN) begin
      if (i_flush) begin
        outstanding <= '0;
        fifo_count  <= '0;
        tag_wr      <= '0;
        tag_rd      <= '0;
        fifo_wr     <= '0;
        fifo_rd     <= '0;
        drop_count  <= drop_load;
        state       <= (drop_load != '0) ? DRAIN : RUN;
      end else begin
        if (accept) tag_wr <= tag_wr + 1'b1;
        if (rsp_take) begin
          tag_rd  <= tag_rd + 1'b1;
          fifo_wr <= fifo_wr + 1'b1;
        end
        if (pop) fifo_rd <= fifo_rd + 1'b1;
        // Counts move by net effect so simultaneous +1/-1 cancel.
        outstanding <= outstanding + CW'(accept) - CW'(rsp_take);
        fifo_count  <= fifo_count + CW'(rsp_take) - CW'(pop);
      end
    end else begin
      if (i_imem_rsp_valid) begin
        drop_count <= drop_count - 1'b1;
        if (drop_count == CW'(1)) state <= RUN;
      end
    end
  end

  // Tag and instruction storage; validity is tracked entirely by the counters above.
  // NOTE: storage arrays carry no reset; counts gate every read, so stale contents are never observed.
  always_ff @(posedge i_clk) begin
    if (accept) tag_mem[tag_wr] <= i_pc;
    if (rsp_take) begin
      fifo_inst[fifo_wr] <= i_imem_rsp_data;
      fifo_pc[fifo_wr]   <= tag_mem[tag_rd];
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a memory model answers requests in order,
// a transaction-level reference model predicts handshakes and delivered
// instructions, and a separate monitor checks decode-side output against a scoreboard.
module tb_instr_fetch_unit;

  localparam int DEPTH  = 2;
  localparam int DATA_W = 32;

  logic              i_clk;
  logic              i_reset_n;
  logic [DATA_W-1:0] i_pc;
  logic              i_pc_valid;
  logic              o_pc_ready;
  logic              i_flush;
  logic              o_imem_req_valid;
  logic [DATA_W-1:0] o_imem_addr;
  logic              i_imem_req_ready;
  logic              i_imem_rsp_valid;
  logic [DATA_W-1:0] i_imem_rsp_data;
  logic              o_inst_valid;
  logic [DATA_W-1:0] o_inst;
  logic [DATA_W-1:0] o_inst_pc;
  logic              i_inst_ready;
  logic              o_busy;

  instr_fetch_unit #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_pc             (i_pc),
    .i_pc_valid       (i_pc_valid),
    .o_pc_ready       (o_pc_ready),
    .i_flush          (i_flush),
    .o_imem_req_valid (o_imem_req_valid),
    .o_imem_addr      (o_imem_addr),
    .i_imem_req_ready (i_imem_req_ready),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .o_inst_valid     (o_inst_valid),
    .o_inst           (o_inst),
    .o_inst_pc        (o_inst_pc),
    .i_inst_ready     (i_inst_ready),
    .o_busy           (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cycle  = 0;

  always @(posedge i_clk) cycle++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [DATA_W-1:0] pc;
    bit                live;
  } flight_t;

  typedef struct {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  flight_t inflight[$];
  exp_t    exp_q[$];
  int      buffered = 0;

  // Requests accepted but unanswered are 'inflight'; a flush kills them, and the
  // unit is draining while any killed request still awaits its response.
  always @(negedge i_clk) begin
    if (!i_reset_n) begin
      inflight.delete();
      exp_q.delete();
      buffered = 0;
    end else begin
      int  dead;
      int  live_n;
      bit  draining;
      bit  exp_req;
      bit  exp_ready;
      dead = 0;
      foreach (inflight[i]) if (!inflight[i].live) dead++;
      live_n    = inflight.size() - dead;
      draining  = (dead > 0);
      exp_req   = i_pc_valid && !i_flush && !draining && (live_n + buffered < DEPTH);
      exp_ready = exp_req && i_imem_req_ready;
      check("req_valid",  o_imem_req_valid, exp_req);
      check("pc_ready",   o_pc_ready,       exp_ready);
      check("inst_valid", o_inst_valid,     buffered > 0);
      check("busy",       o_busy,           (inflight.size() > 0) || (buffered > 0));
      if (o_imem_req_valid) check("imem_addr", o_imem_addr, i_pc);

      if (buffered > 0 && i_inst_ready && !i_flush) buffered--;
      if (i_flush) begin
        foreach (inflight[i]) inflight[i].live = 1'b0;
        exp_q.delete();
        buffered = 0;
      end
      if (i_imem_rsp_valid && inflight.size() > 0) begin
        flight_t f;
        f = inflight.pop_front();
        if (f.live) begin
          exp_q.push_back('{pc: f.pc, data: i_imem_rsp_data, cyc: cycle});
          buffered++;
        end
      end
      if (exp_ready) inflight.push_back('{pc: i_pc, live: 1'b1});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge i_clk) begin
    if (i_reset_n && o_inst_valid && i_inst_ready && !i_flush) begin
      check("sb_avail", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("inst_pc",    o_inst_pc,     e.pc);
        check("inst_data",  o_inst,        e.data);
        check("no_bypass",  e.cyc < cycle, 1'b1);
      end
    end
  end

  // ---------------- stimulus / memory model ----------------
  logic [DATA_W-1:0] mem_q[$];
  logic [DATA_W-1:0] pc_list[$];
  bit rand_pc   = 1'b0;
  int p_pcv     = 0;
  int p_mr      = 100;
  int p_rsp     = 100;
  int p_ir      = 100;
  bit flush_once = 1'b0;
  bit rsp_once   = 1'b0;

  function automatic bit chance(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  // One clock: observe the edge about to happen, then drive new inputs after it.
  task automatic step();
    @(negedge i_clk);
    if (i_reset_n && o_pc_ready) begin
      mem_q.push_back(i_pc);
      if (pc_list.size() > 0) void'(pc_list.pop_front());
    end
    if (i_imem_rsp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
    @(posedge i_clk);
    #1;
    if (pc_list.size() > 0) begin
      i_pc_valid = 1'b1;
      i_pc       = pc_list[0];
    end else begin
      i_pc_valid = rand_pc && chance(p_pcv);
      i_pc       = $urandom();
    end
    i_imem_req_ready = chance(p_mr);
    if (rsp_once) begin
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = (mem_q.size() > 0) ? mem_q[0] + 32'hA0 : $urandom();
      rsp_once = 1'b0;
    end else if (mem_q.size() > 0 && chance(p_rsp)) begin
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = mem_q[0] + 32'hA0;
    end else begin
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data  = $urandom();
    end
    i_inst_ready = chance(p_ir);
    i_flush      = flush_once;
    flush_once   = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Let everything in flight finish; an expired budget counts as a failure.
  task automatic wait_idle(input string name);
    int k;
    rand_pc = 1'b0; p_mr = 100; p_rsp = 100; p_ir = 100;
    k = 0;
    while ((o_busy || mem_q.size() > 0 || pc_list.size() > 0) && k < 300) begin
      step();
      k++;
    end
    check(name, o_busy, 1'b0);
    run(2);
  endtask

  initial begin
    i_reset_n = 1'b0; i_pc = '0; i_pc_valid = 1'b1; i_flush = 1'b0;
    i_imem_req_ready = 1'b1; i_imem_rsp_valid = 1'b0; i_imem_rsp_data = '0;
    i_inst_ready = 1'b1;
    #1;
    check("rst_req_valid",  o_imem_req_valid, 1'b0);
    check("rst_pc_ready",   o_pc_ready,       1'b0);
    check("rst_inst_valid", o_inst_valid,     1'b0);
    check("rst_inst",       o_inst,           '0);
    check("rst_inst_pc",    o_inst_pc,        '0);
    check("rst_busy",       o_busy,           1'b0);
    i_pc_valid = 1'b0;
    @(negedge i_clk);
    #2 i_reset_n = 1'b1;

    // Streaming PCs 0..3 with a one-cycle memory.
    pc_list = '{32'h0, 32'h1, 32'h2, 32'h3};
    run(14);
    wait_idle("stream_idle");

    // Decode backpressure: credits run out, nothing lost.
    p_ir = 0;
    pc_list = '{32'h50, 32'h54, 32'h58, 32'h5C};
    run(8);
    check("bp_stall", o_pc_ready, 1'b0);
    p_ir = 100;
    wait_idle("bp_idle");

    // Flush with two requests outstanding, then refetch 0x40.
    p_rsp = 0; p_ir = 0;
    pc_list = '{32'h10, 32'h14};
    run(3);
    flush_once = 1'b1;
    run(2);
    check("flush_inst_valid", o_inst_valid, 1'b0);
    p_rsp = 100; p_ir = 100;
    pc_list = '{32'h40};
    wait_idle("flush_idle");

    // Flush coinciding with the only response.
    p_rsp = 0;
    pc_list = '{32'h20};
    run(3);
    rsp_once = 1'b1; flush_once = 1'b1;
    run(2);
    check("flush_rsp_busy",  o_busy,       1'b0);
    check("flush_rsp_valid", o_inst_valid, 1'b0);
    wait_idle("flush_rsp_idle");

    // Asynchronous reset with one buffered and one outstanding.
    p_rsp = 0; p_ir = 0;
    pc_list = '{32'h30, 32'h34};
    run(3);
    rsp_once = 1'b1;
    run(2);
    check("pre_rst_valid", o_inst_valid, 1'b1);
    #2 i_reset_n = 1'b0;
    i_pc_valid = 1'b1;
    #1;
    check("arst_req_valid",  o_imem_req_valid, 1'b0);
    check("arst_pc_ready",   o_pc_ready,       1'b0);
    check("arst_inst_valid", o_inst_valid,     1'b0);
    check("arst_inst",       o_inst,           '0);
    check("arst_inst_pc",    o_inst_pc,        '0);
    check("arst_busy",       o_busy,           1'b0);
    @(negedge i_clk);
    i_pc_valid = 1'b0; i_imem_rsp_valid = 1'b0; i_flush = 1'b0;
    #2 i_reset_n = 1'b1;
    p_rsp = 100;
    run(4);
    check("late_rsp_busy", o_busy, 1'b0);
    wait_idle("arst_idle");

    // Randomized traffic with occasional flushes.
    rand_pc = 1'b1;
    for (int blk = 0; blk < 40; blk++) begin
      p_pcv = int'($urandom_range(30, 100));
      p_mr  = int'($urandom_range(30, 100));
      p_rsp = int'($urandom_range(20, 100));
      p_ir  = int'($urandom_range(10, 100));
      for (int i = 0; i < 50; i++) begin
        flush_once = chance(3);
        step();
      end
    end
    wait_idle("rand_idle");
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
